// File: rtl/pila_pkg.sv
// Shared constants for the return-address stack: default geometry and the
// count-width helper used wherever the stack is instantiated.
package pila_pkg;
  localparam int PILA_WIDTH = 10;
  localparam int PILA_DEPTH = 16;

  // count must represent 0..depth inclusive
  function automatic int pila_cw(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pila_ctrl.sv
// Stack pointer/count and sticky flag control. Decides which slot (if any)
// the storage writes this cycle and which slot is currently on top.
module pila_ctrl
  import pila_pkg::*;
#(
  parameter int DEPTH = PILA_DEPTH,
  parameter int CW    = pila_cw(DEPTH),
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          err_clr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic [IW-1:0] rd_idx
);

  logic [CW-1:0] cnt_n;
  logic          ovf_n, udf_n;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign rd_idx = IW'(count - CW'(1));

  always_comb begin
    cnt_n  = count;
    ovf_n  = err_clr ? 1'b0 : overflow;
    udf_n  = err_clr ? 1'b0 : underflow;
    wr_en  = 1'b0;
    wr_idx = IW'(count);
    // a flag-setting event below overrides the err_clr clear above
    unique case ({push, pop})
      2'b10: begin
        if (full) ovf_n = 1'b1;
        else begin
          cnt_n = count + CW'(1);
          wr_en = 1'b1;
        end
      end
      2'b01: begin
        if (empty) udf_n = 1'b1;
        else       cnt_n = count - CW'(1);
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) begin
          cnt_n = CW'(1);
          udf_n = 1'b1;
        end else begin
          wr_idx = rd_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_n;
      overflow  <= ovf_n;
      underflow <= udf_n;
    end
  end

endmodule

// File: rtl/pila_param.sv
// Parameterized LIFO (return-address stack). Holds the storage array and the
// top-of-stack mux; pointer and flag logic live in pila_ctrl.
module pila_param
  import pila_pkg::*;
#(
  parameter int WIDTH = PILA_WIDTH,
  parameter int DEPTH = PILA_DEPTH,
  parameter int CW    = pila_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             wr_en;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  pila_ctrl #(.DEPTH(DEPTH), .CW(CW), .IW(IW)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .err_clr  (err_clr),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx)
  );

  // storage is not reset; stale slots are masked by the empty check on top
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_idx] <= din;
  end

  assign top = empty ? '0 : mem[rd_idx];

endmodule
